// File: rtl/phase_alu_sequencer.sv
// Phase-driven multi-cycle ALU: follows the one-hot phase stream of the modulo-5 counter,
// loads A/B, computes, writes back, and aborts with a sticky error on an illegal or stalled phase.
module phase_alu_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [4:0]       phase,
    output logic             begin_signal,
    output logic             end_signal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             phase_error
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic {StIdle, StRun} state_e;
    state_e state_q, state_d;

    logic [2:0]       exp_q, exp_d, last_q, last_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, tmp_q, tmp_d;
    logic             tmp_c_q, tmp_c_d, tmp_v_q, tmp_v_d;
    logic             pend_q, pend_d;
    logic             begin_q, begin_d, end_q, end_d, busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, err_q, err_d;

    logic             held, timed_out, advance;
    logic             accept, run_held, run_adv, run_abort;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_v;

    always_comb begin
        held      = (phase == (5'b00001 << last_q));
        timed_out = (tcnt_q == TW'(TIMEOUT - 1));
        advance   = !held && (phase == (5'b00001 << exp_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        run_held  = 1'b0;
        run_adv   = 1'b0;
        run_abort = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (held) begin
                    if (timed_out) begin
                        run_abort = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        run_held = 1'b1;
                    end
                end else if (advance) begin
                    run_adv = 1'b1;
                    if (exp_q == 3'd0) state_d = StIdle;
                end else begin
                    run_abort = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Subtraction reuses the adder as A + ~B + 1, so carry doubles as no-borrow.
    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, (op_q[0] ? ~b_q : b_q)} + {{WIDTH{1'b0}}, op_q[0]};
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        unique case (op_q)
            2'b00, 2'b01: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ op_q[0]))
                        && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            2'b10:   alu_r = a_q & b_q;
            default: alu_r = a_q | b_q;
        endcase
    end

    always_comb begin
        exp_d    = exp_q;
        last_d   = last_q;
        tcnt_d   = tcnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        tmp_d    = tmp_q;
        tmp_c_d  = tmp_c_q;
        tmp_v_d  = tmp_v_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        err_d    = err_q;
        pend_d   = 1'b0;
        begin_d  = 1'b0;
        end_d    = pend_q;
        done_d   = 1'b0;
        busy_d   = (state_d == StRun);
        if (accept) begin
            op_d    = op;
            begin_d = 1'b1;
            err_d   = 1'b0;
            exp_d   = 3'd1;
            last_d  = 3'd0;
            tcnt_d  = '0;
        end
        if (run_held) tcnt_d = tcnt_q + 1'b1;
        if (run_adv) begin
            last_d = exp_q;
            exp_d  = (exp_q == 3'd4) ? 3'd0 : exp_q + 3'd1;
            tcnt_d = '0;
            unique case (exp_q)
                3'd1: a_d = data_in;
                3'd2: b_d = data_in;
                3'd3: begin
                    tmp_d   = alu_r;
                    tmp_c_d = alu_c;
                    tmp_v_d = alu_v;
                end
                3'd4: begin
                    result_d = tmp_q;
                    carry_d  = tmp_c_q;
                    ovf_d    = tmp_v_q;
                    zero_d   = (tmp_q == '0);
                    end_d    = 1'b1;
                end
                default: done_d = 1'b1;
            endcase
        end
        if (run_abort) begin
            err_d = 1'b1;
            end_d = 1'b1;
        end
    end

    // pend_q makes end_signal pulse once after reset so the counter is forced idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q    <= '0;
            last_q   <= '0;
            tcnt_q   <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tmp_q    <= '0;
            tmp_c_q  <= 1'b0;
            tmp_v_q  <= 1'b0;
            pend_q   <= 1'b1;
            begin_q  <= 1'b0;
            end_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            exp_q    <= exp_d;
            last_q   <= last_d;
            tcnt_q   <= tcnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tmp_q    <= tmp_d;
            tmp_c_q  <= tmp_c_d;
            tmp_v_q  <= tmp_v_d;
            pend_q   <= pend_d;
            begin_q  <= begin_d;
            end_q    <= end_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign begin_signal = begin_q;
    assign end_signal   = end_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign carry        = carry_q;
    assign overflow     = ovf_q;
    assign zero         = zero_q;
    assign phase_error  = err_q;

endmodule

// File: tb/tb_phase_alu_sequencer.sv
// Bench for phase_alu_sequencer: directed and random phase streams checked against
// an operation-level reference model.
module tb_phase_alu_sequencer;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [1:0] op;
    logic [7:0] data_in;
    logic [4:0] phase;
    logic       begin_signal, end_signal, busy, done, carry, overflow, zero, phase_error;
    logic [7:0] result;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] ph_q[$];
    logic [7:0] dt_q[$];
    bit         st_q[$];

    int cur_r = 0, cur_c = 0, cur_v = 0, cur_z = 0, cur_err = 0;

    phase_alu_sequencer #(.WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in), .phase(phase),
        .begin_signal(begin_signal), .end_signal(end_signal), .busy(busy), .done(done),
        .result(result), .carry(carry), .overflow(overflow), .zero(zero),
        .phase_error(phase_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at negedge; outputs of the preceding posedge are checked at negedge.
    task automatic step(input logic [4:0] p, input logic [7:0] d, input logic s);
        phase   = p;
        data_in = d;
        start   = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input int b, input int e, input int bz,
                              input int dn, input int er, input int r, input int c,
                              input int v, input int z);
        check_eq({tag, ".begin"}, begin_signal, b);
        check_eq({tag, ".end"}, end_signal, e);
        check_eq({tag, ".busy"}, busy, bz);
        check_eq({tag, ".done"}, done, dn);
        check_eq({tag, ".err"}, phase_error, er);
        check_eq({tag, ".result"}, result, r);
        check_eq({tag, ".carry"}, carry, c);
        check_eq({tag, ".ovf"}, overflow, v);
        check_eq({tag, ".zero"}, zero, z);
    endtask

    function automatic void ref_alu(input int o, input int a, input int b,
                                    output int r, output int c, output int v);
        int sa, sb, s;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        r = 0; c = 0; v = 0;
        case (o)
            0: begin r = (a + b) & 255; c = (a + b) > 255; s = sa + sb; v = (s > 127) || (s < -128); end
            1: begin r = (a - b) & 255; c = (a >= b); s = sa - sb; v = (s > 127) || (s < -128); end
            2: r = a & b;
            default: r = a | b;
        endcase
    endfunction

    task automatic push(input logic [4:0] p, input logic [7:0] d);
        ph_q.push_back(p);
        dt_q.push_back(d);
        st_q.push_back($urandom_range(0, 3) == 0);
    endtask

    task automatic build_legal(input logic [7:0] a, input logic [7:0] b, input int hold);
        ph_q.delete(); dt_q.delete(); st_q.delete();
        for (int i = 1; i <= 4; i++) begin
            for (int j = 0; j < hold; j++) begin
                logic [7:0] d;
                d = $urandom;
                if (j == 0 && i == 1) d = a;
                if (j == 0 && i == 2) d = b;
                push(5'b00001 << i, d);
            end
        end
        push(5'b00001, $urandom);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o);
        int term, kind, p4k, ei, li, hold, ma, mb, nr, nc, nv, nz;
        logic [4:0] idle_ph;
        term = -1; kind = 0; p4k = -1; ei = 1; li = 0; hold = 0; ma = 0; mb = 0;
        for (int k = 0; k < ph_q.size(); k++) begin
            if (int'(ph_q[k]) == (1 << li)) begin
                hold++;
                if (hold == TIMEOUT) begin term = k; kind = 2; break; end
            end else if (int'(ph_q[k]) == (1 << ei)) begin
                hold = 0;
                if (ei == 1) ma = dt_q[k];
                if (ei == 2) mb = dt_q[k];
                if (ei == 4) p4k = k;
                if (ei == 0) begin term = k; kind = 1; break; end
                li = ei;
                ei = (ei + 1) % 5;
            end else begin
                term = k; kind = 2; break;
            end
        end
        if (term < 0) begin
            push(5'b00000, 8'h00);
            term = ph_q.size() - 1;
            kind = 2;
        end
        ref_alu(o, ma, mb, nr, nc, nv);
        nz = (nr == 0);
        idle_ph = ($urandom_range(0, 1) == 0) ? 5'b00001 : 5'b00110;
        op = o;
        step(idle_ph, $urandom, 1'b1);
        check_outs({tag, ".accept"}, 1, 0, 1, 0, 0, cur_r, cur_c, cur_v, cur_z);
        for (int k = 0; k <= term; k++) begin
            bit newv;
            op = $urandom;
            step(ph_q[k], dt_q[k], st_q[k]);
            newv = (p4k >= 0) && (k >= p4k);
            check_outs($sformatf("%s.c%0d", tag, k), 0,
                       (k == p4k) || (k == term && kind == 2), k < term,
                       k == term && kind == 1, k == term && kind == 2,
                       newv ? nr : cur_r, newv ? nc : cur_c, newv ? nv : cur_v,
                       newv ? nz : cur_z);
        end
        if (p4k >= 0) begin cur_r = nr; cur_c = nc; cur_v = nv; cur_z = nz; end
        cur_err = (kind == 2);
        step(5'b00001, $urandom, 1'b0);
        check_outs({tag, ".after"}, 0, 0, 0, 0, cur_err, cur_r, cur_c, cur_v, cur_z);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; data_in = 8'h00; phase = 5'b00001;
        @(negedge clk);
        step(5'b00001, 8'h00, 1'b0);
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(5'b00001, 8'h00, 1'b0);
        check_outs("post_reset", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(5'b00001, 8'h00, 1'b0);
        check_outs("post_reset2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        build_legal(8'h7F, 8'h01, 1);
        run_op("add", 2'b00);
        check_eq("add.spec", {result, carry, overflow, zero}, {8'h80, 3'b010});
        build_legal(8'h10, 8'h20, 1);
        run_op("sub1", 2'b01);
        check_eq("sub1.spec", {result, carry, overflow}, {8'hF0, 2'b00});
        build_legal(8'h20, 8'h10, 1);
        run_op("sub2", 2'b01);
        check_eq("sub2.spec", {result, carry}, {8'h10, 1'b1});
        build_legal(8'hF0, 8'h0F, 3);
        run_op("and_hold", 2'b10);
        check_eq("and.spec", {result, carry, overflow, zero}, {8'h00, 3'b001});

        ph_q.delete(); dt_q.delete(); st_q.delete();
        push(5'b00010, 8'h55); push(5'b01000, 8'h00);
        run_op("skip", 2'b00);
        check_eq("skip.spec", {phase_error, result}, {1'b1, 8'h00});
        build_legal(8'h01, 8'h01, 2);
        run_op("clear_err", 2'b11);

        ph_q.delete(); dt_q.delete(); st_q.delete();
        push(5'b00010, 8'h12); push(5'b00110, 8'h00);
        run_op("multi", 2'b00);

        ph_q.delete(); dt_q.delete(); st_q.delete();
        push(5'b00010, 8'h12); push(5'b00100, 8'h34);
        for (int i = 0; i < 12; i++) push(5'b00100, $urandom);
        run_op("timeout", 2'b00);

        // Reset while the counter sits in phase 2.
        op = 2'b00;
        step(5'b00001, 8'h00, 1'b1);
        step(5'b00010, 8'h99, 1'b0);
        step(5'b00100, 8'h11, 1'b0);
        reset = 1'b1;
        step(5'b00100, 8'h22, 1'b0);
        check_outs("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(5'b00001, 8'h00, 1'b0);
        check_outs("mid_release", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cur_r = 0; cur_c = 0; cur_v = 0; cur_z = 0; cur_err = 0;
        build_legal(8'h03, 8'h04, 1);
        run_op("add_after_reset", 2'b00);
        check_eq("add_after_reset.spec", result, 8'h07);

        for (int n = 0; n < 40; n++) begin
            build_legal($urandom, $urandom, $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) begin
                int idx;
                idx = $urandom_range(0, ph_q.size() - 2);
                ph_q[idx] = $urandom;
            end
            run_op($sformatf("rnd%0d", n), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
